// File: rtl/aline_acquisition_controller_if.sv
// rtl/aline_acquisition_controller_if.sv - acquisition controller control, write-port and handoff signals
interface aline_acquisition_controller_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int LINE_WIDTH = 10
);
    logic                  enable;
    logic                  trigger;
    logic                  line_ack;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_en;
    logic                  wr_bank;
    logic                  line_ready;
    logic                  line_bank;
    logic [LINE_WIDTH-1:0] line_index;
    logic                  frame_done;
    logic                  overrun;
    logic                  busy;

    modport master (
        input  enable, trigger, line_ack,
        output wr_addr, wr_en, wr_bank, line_ready, line_bank,
               line_index, frame_done, overrun, busy
    );

    modport slave (
        output enable, trigger, line_ack,
        input  wr_addr, wr_en, wr_bank, line_ready, line_bank,
               line_index, frame_done, overrun, busy
    );
endinterface

// File: rtl/aline_acquisition_controller.sv
// rtl/aline_acquisition_controller.sv - per-sweep A-line capture into a ping-pong buffer
module aline_acquisition_controller #(
    parameter int NSAMPLES   = 1170,
    parameter int ADDR_WIDTH = 11,
    parameter int NLINES     = 512,
    parameter int LINE_WIDTH = 10
) (
    input  logic clock,
    input  logic reset_n,
    aline_acquisition_controller_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NSAMPLES - 1);
    localparam logic [LINE_WIDTH-1:0] LAST_LINE = LINE_WIDTH'(NLINES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t                state_q, state_d;
    logic                  trigger_q, trigger_d;
    logic                  enable_q, enable_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [1:0]            full_q, full_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [LINE_WIDTH-1:0] line_index_q, line_index_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overrun_q, overrun_d;

    logic trig_edge;
    logic line_ready;

    assign trig_edge  = bus.trigger & ~trigger_q;
    assign line_ready = |full_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            trigger_q    <= 1'b0;
            enable_q     <= 1'b0;
            addr_q       <= '0;
            wr_bank_q    <= 1'b0;
            full_q       <= 2'b00;
            rd_bank_q    <= 1'b0;
            line_index_q <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            trigger_q    <= trigger_d;
            enable_q     <= enable_d;
            addr_q       <= addr_d;
            wr_bank_q    <= wr_bank_d;
            full_q       <= full_d;
            rd_bank_q    <= rd_bank_d;
            line_index_q <= line_index_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        trigger_d    = bus.trigger;
        enable_d     = bus.enable;
        addr_d       = addr_q;
        wr_bank_d    = wr_bank_q;
        full_d       = full_q;
        rd_bank_d    = rd_bank_q;
        line_index_d = line_index_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        // Banks fill alternately, so the oldest full bank is just a toggling read pointer.
        if (line_ready && bus.line_ack) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (bus.enable && !enable_q) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (trig_edge) begin
                    // Free status comes from full_q, i.e. before any same-cycle ack lands.
                    if (full_q[wr_bank_q]) begin
                        overrun_d = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                        addr_d  = '0;
                    end
                end
            end
            CAPTURE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d            = '0;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    state_d           = bus.enable ? ARMED : IDLE;
                    if (line_index_q == LAST_LINE) begin
                        line_index_d = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        line_index_d = line_index_q + 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.wr_addr    = addr_q;
    assign bus.wr_en      = (state_q == CAPTURE);
    assign bus.busy       = (state_q == CAPTURE);
    assign bus.wr_bank    = wr_bank_q;
    assign bus.line_ready = line_ready;
    assign bus.line_bank  = rd_bank_q;
    assign bus.line_index = line_index_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_aline_acquisition_controller.sv
// tb/tb_aline_acquisition_controller.sv - self-checking bench for aline_acquisition_controller
module tb_aline_acquisition_controller;
    localparam int NS = 1170;
    localparam int AW = 11;
    localparam int NL = 4;
    localparam int LW = 10;

    typedef struct {
        logic en, trig, ack;
        int   cycles;
        logic push, push_bank;
        logic wr_en;
        int   addr;
        logic wr_bank, rdy, lbank;
        int   idx;
        logic fd, ov;
    } vec_t;

    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    logic sb_q[$];

    aline_acquisition_controller_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    aline_acquisition_controller #(
        .NSAMPLES(NS), .ADDR_WIDTH(AW), .NLINES(NL), .LINE_WIDTH(LW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic v(input logic en, input logic trig, input logic ack, input int cycles,
                     input logic push, input logic pbank, input logic wr_en, input int addr,
                     input logic wbank, input logic rdy, input logic lb, input int idx,
                     input logic fd, input logic ov);
        vec_t r;
        r.en = en; r.trig = trig; r.ack = ack; r.cycles = cycles;
        r.push = push; r.push_bank = pbank; r.wr_en = wr_en; r.addr = addr;
        r.wr_bank = wbank; r.rdy = rdy; r.lbank = lb; r.idx = idx; r.fd = fd; r.ov = ov;
        vecs.push_back(r);
    endtask

    task automatic chk_outputs(input string p, input logic wr_en, input int addr, input logic wbank,
                               input logic rdy, input logic lb, input int idx, input logic fd,
                               input logic ov);
        chk({p, "_wr_en"}, int'(bus.wr_en), int'(wr_en));
        chk({p, "_busy"}, int'(bus.busy), int'(wr_en));
        chk({p, "_wr_addr"}, int'(bus.wr_addr), addr);
        chk({p, "_wr_bank"}, int'(bus.wr_bank), int'(wbank));
        chk({p, "_line_ready"}, int'(bus.line_ready), int'(rdy));
        chk({p, "_line_bank"}, int'(bus.line_bank), int'(lb));
        chk({p, "_line_index"}, int'(bus.line_index), idx);
        chk({p, "_frame_done"}, int'(bus.frame_done), int'(fd));
        chk({p, "_overrun"}, int'(bus.overrun), int'(ov));
    endtask

    // Write-run monitor: each run must match a queued bank, count NS writes, addresses 0..NS-1.
    logic mon_in_run = 1'b0;
    int   mon_cnt    = 0;
    int   mon_errs   = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            mon_in_run = 1'b0;
            mon_cnt    = 0;
            mon_errs   = 0;
        end else if (bus.wr_en) begin
            if (!mon_in_run) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_run", 1, 0);
                end else begin
                    chk("sb_run_bank", int'(bus.wr_bank), int'(sb_q.pop_front()));
                end
                mon_in_run = 1'b1;
                mon_cnt    = 0;
                mon_errs   = 0;
            end
            if (int'(bus.wr_addr) != mon_cnt) mon_errs++;
            mon_cnt++;
        end else if (mon_in_run) begin
            chk("sb_run_length", mon_cnt, NS);
            chk("sb_run_addr_errors", mon_errs, 0);
            mon_in_run = 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        bus.enable   = 1'b0;
        bus.trigger  = 1'b0;
        bus.line_ack = 1'b0;

        //  en trg ack  cyc  push pb  wen addr  wb rdy lb idx fd ov
        v(1, 0, 0, 2,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 1,    1, 0, 1, 0,    0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 1169, 0, 0, 1, 1169, 0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 1,    0, 0, 0, 0,    1, 1, 0, 1, 0, 0);
        v(1, 1, 0, 1,    1, 1, 1, 0,    1, 1, 0, 1, 0, 0);
        v(1, 0, 0, 1170, 0, 0, 0, 0,    0, 1, 0, 2, 0, 0);
        v(1, 1, 0, 1,    0, 0, 0, 0,    0, 1, 0, 2, 0, 1);
        v(1, 0, 1, 1,    0, 0, 0, 0,    0, 1, 1, 2, 0, 1);
        v(1, 1, 0, 1,    1, 0, 1, 0,    0, 1, 1, 2, 0, 1);
        v(1, 0, 0, 1170, 0, 0, 0, 0,    1, 1, 1, 3, 0, 1);
        v(1, 0, 1, 1,    0, 0, 0, 0,    1, 1, 0, 3, 0, 1);
        v(0, 0, 0, 1,    0, 0, 0, 0,    1, 1, 0, 3, 0, 1);
        v(1, 0, 0, 2,    0, 0, 0, 0,    1, 1, 0, 3, 0, 0);
        v(1, 1, 0, 1,    1, 1, 1, 0,    1, 1, 0, 3, 0, 0);
        v(1, 0, 0, 1169, 0, 0, 1, 1169, 1, 1, 0, 3, 0, 0);
        v(1, 0, 1, 1,    0, 0, 0, 0,    0, 1, 1, 0, 1, 0);
        v(1, 0, 0, 1,    0, 0, 0, 0,    0, 1, 1, 0, 0, 0);
        v(1, 0, 1, 1,    0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 500,  1, 0, 1, 499,  0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 670,  0, 0, 1, 1169, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 1,    0, 0, 0, 0,    1, 1, 0, 1, 0, 0);
        v(0, 1, 0, 1,    0, 0, 0, 0,    1, 1, 0, 1, 0, 0);
        v(0, 0, 1, 1,    0, 0, 0, 0,    1, 0, 1, 1, 0, 0);
        v(0, 0, 1, 3,    0, 0, 0, 0,    1, 0, 1, 1, 0, 0);

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.enable   = vecs[i].en;
            bus.trigger  = vecs[i].trig;
            bus.line_ack = vecs[i].ack;
            if (vecs[i].push) sb_q.push_back(vecs[i].push_bank);
            repeat (vecs[i].cycles) @(negedge clock);
            chk_outputs($sformatf("v%0d", i), vecs[i].wr_en, vecs[i].addr, vecs[i].wr_bank,
                        vecs[i].rdy, vecs[i].lbank, vecs[i].idx, vecs[i].fd, vecs[i].ov);
        end

        // Asynchronous reset in the middle of a capture into bank 1.
        bus.line_ack = 1'b0;
        bus.enable   = 1'b1;
        repeat (2) @(negedge clock);
        bus.trigger = 1'b1;
        sb_q.push_back(1'b1);
        repeat (300) @(negedge clock);
        bus.trigger = 1'b0;
        chk_outputs("pre_reset", 1, 299, 1, 0, 1, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (1200) @(negedge clock);
        chk_outputs("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        bus.trigger = 1'b1;
        sb_q.push_back(1'b0);
        @(negedge clock);
        chk_outputs("post_reset_start", 1, 0, 0, 0, 0, 0, 0, 0);
        bus.trigger = 1'b0;
        repeat (NS) @(negedge clock);
        chk_outputs("post_reset_done", 0, 0, 1, 1, 0, 1, 0, 0);
        @(negedge clock);
        chk("sb_queue_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
